// File: rtl/hamming_class_search.sv
// -----------------------------------------------------------------------------
// hamming_class_search
//
// Associative-search stage that sits after class_vec_gen. A query hypervector
// arrives as NUM_FRAMES frames, frame 0 first. The block then walks every
// (class, frame) address of class_vec_gen, adds up the Hamming distance between
// each stored class and the query, and reports the class with the smallest
// total distance. On a tie the lower class index wins.
//
// Ports:
//   clk, rst_n          single clock; synchronous active-low reset
//   q_data/q_valid/q_ready        query frame stream (ready/valid)
//   frame_id/frame_index          registered address to class_vec_gen
//   class_vec_in                  class frame for that address, same cycle
//   result_valid/result_ready     result handshake
//   result_class/result_dist      argmin class and its distance
//   busy                          high while searching or draining
// -----------------------------------------------------------------------------
module hamming_class_search #(
    parameter int FRAME_WIDTH     = 64,
    parameter int NUM_FRAMES      = 3,
    parameter int NUM_CLASSES     = 8,
    parameter int CLASS_ID_WIDTH  = 3,
    parameter int FRAME_IDX_WIDTH = 2,
    parameter int DIST_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FRAME_WIDTH-1:0]     q_data,
    input  logic                       q_valid,
    output logic                       q_ready,
    output logic [CLASS_ID_WIDTH-1:0]  frame_id,
    output logic [FRAME_IDX_WIDTH-1:0] frame_index,
    input  logic [FRAME_WIDTH-1:0]     class_vec_in,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [CLASS_ID_WIDTH-1:0]  result_class,
    output logic [DIST_WIDTH-1:0]      result_dist,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SEARCH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [FRAME_IDX_WIDTH-1:0] LAST_FRM = FRAME_IDX_WIDTH'(NUM_FRAMES - 1);
    localparam logic [CLASS_ID_WIDTH-1:0]  LAST_CLS = CLASS_ID_WIDTH'(NUM_CLASSES - 1);

    state_t                     state_q;
    logic [FRAME_WIDTH-1:0]     buffer_q [NUM_FRAMES];
    logic [FRAME_IDX_WIDTH-1:0] ld_cnt_q;
    logic [FRAME_IDX_WIDTH-1:0] frm_cnt_q;
    logic [CLASS_ID_WIDTH-1:0]  cls_cnt_q;
    logic                       q_ready_q;
    logic                       busy_q;
    logic                       result_valid_q;

    // Stage 1 -> stage 2 pipeline register and its tags.
    logic [DIST_WIDTH-1:0]      pc_q;
    logic                       pc_vld_q;
    logic                       pc_first_q;
    logic                       pc_last_q;
    logic [CLASS_ID_WIDTH-1:0]  pc_cls_q;

    // Stage 2 state.
    logic [DIST_WIDTH-1:0]      acc_q;
    logic [DIST_WIDTH-1:0]      best_dist_q;
    logic [CLASS_ID_WIDTH-1:0]  best_cls_q;

    logic [DIST_WIDTH-1:0]      pc_d;
    logic [DIST_WIDTH-1:0]      cand_d;

    function automatic logic [DIST_WIDTH-1:0] popcount(input logic [FRAME_WIDTH-1:0] v);
        logic [DIST_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < FRAME_WIDTH; i++) begin
            n = n + DIST_WIDTH'(v[i]);
        end
        return n;
    endfunction

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        pc_d   = popcount(class_vec_in ^ buffer_q[frm_cnt_q]);
        // The first-frame case bypasses acc_q, which still holds the previous class total.
        cand_d = (pc_first_q ? '0 : acc_q) + pc_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_LOAD;
            ld_cnt_q       <= '0;
            frm_cnt_q      <= '0;
            cls_cnt_q      <= '0;
            q_ready_q      <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            pc_q           <= '0;
            pc_vld_q       <= 1'b0;
            pc_first_q     <= 1'b0;
            pc_last_q      <= 1'b0;
            pc_cls_q       <= '0;
            acc_q          <= '0;
            best_dist_q    <= '0;
            best_cls_q     <= '0;
            // NOTE: the query buffer is only a few flops, and clearing it makes the reset state fully defined.
            for (int i = 0; i < NUM_FRAMES; i++) begin
                buffer_q[i] <= '0;
            end
        end else begin
            pc_vld_q <= 1'b0;

            case (state_q)
                S_LOAD: begin
                    if (q_valid && q_ready_q) begin
                        buffer_q[ld_cnt_q] <= q_data;
                        if (ld_cnt_q == LAST_FRM) begin
                            ld_cnt_q  <= '0;
                            frm_cnt_q <= '0;
                            cls_cnt_q <= '0;
                            q_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= S_SEARCH;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + 1'b1;
                        end
                    end
                end

                S_SEARCH: begin
                    pc_q       <= pc_d;
                    pc_vld_q   <= 1'b1;
                    pc_first_q <= (frm_cnt_q == '0);
                    pc_last_q  <= (frm_cnt_q == LAST_FRM);
                    pc_cls_q   <= cls_cnt_q;
                    if (frm_cnt_q == LAST_FRM) begin
                        if (cls_cnt_q == LAST_CLS) begin
                            // The address stays on the last pair through DRAIN.
                            state_q <= S_DRAIN;
                        end else begin
                            frm_cnt_q <= '0;
                            cls_cnt_q <= cls_cnt_q + 1'b1;
                        end
                    end else begin
                        frm_cnt_q <= frm_cnt_q + 1'b1;
                    end
                end

                S_DRAIN: begin
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b1;
                    state_q        <= S_DONE;
                end

                S_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        q_ready_q      <= 1'b1;
                        state_q        <= S_LOAD;
                    end
                end

                default: state_q <= S_LOAD;
            endcase

            // Stage 2: per-class accumulation and running minimum.
            if (pc_vld_q) begin
                acc_q <= pc_first_q ? pc_q : acc_q + pc_q;
                // Class 0 always seeds the minimum; strict less-than keeps the lower index on ties.
                if (pc_last_q && ((pc_cls_q == '0) || (cand_d < best_dist_q))) begin
                    best_dist_q <= cand_d;
                    best_cls_q  <= pc_cls_q;
                end
            end
        end
    end

    assign q_ready      = q_ready_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign frame_id     = cls_cnt_q;
    assign frame_index  = frm_cnt_q;
    assign result_class = best_cls_q;
    assign result_dist  = best_dist_q;

endmodule

// File: tb/tb_hamming_class_search.sv
// -----------------------------------------------------------------------------
// tb_hamming_class_search
//
// Directed bench for hamming_class_search. A small class ROM inside the bench
// stands in for class_vec_gen and answers the DUT address combinationally.
// Each scenario task drives a query, waits for the result and compares the
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hamming_class_search;

    localparam int FW = 64;
    localparam logic [FW-1:0] BASE = 64'hD5900F3A6B2C1E47;
    localparam logic [FW-1:0] TIEQ = 64'h0123456789ABCDEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] q_data;
    logic          q_valid;
    logic          q_ready;
    logic [2:0]    frame_id;
    logic [1:0]    frame_index;
    logic [FW-1:0] class_vec_in;
    logic          result_valid;
    logic          result_ready;
    logic [2:0]    result_class;
    logic [7:0]    result_dist;
    logic          busy;

    logic [FW-1:0] rom [0:7][0:2];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hamming_class_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_data       (q_data),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_dist  (result_dist),
        .busy         (busy)
    );

    always_comb begin
        class_vec_in = '0;
        if (frame_index < 2'd3) class_vec_in = rom[frame_id][frame_index];
    end

    // Class 4 holds BASE in every frame; class c differs from BASE in byte c of every frame.
    task automatic set_default_rom();
        logic [FW-1:0] m;
        for (int c = 0; c < 8; c++) begin
            m = 64'hFF;
            m = m << (8 * c);
            for (int f = 0; f < 3; f++) rom[c][f] = (c == 4) ? BASE : (BASE ^ m);
        end
    endtask

    task automatic load_frames(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                               input logic [FW-1:0] f2, input int gap0, input int gap1);
        logic [FW-1:0] fr [3];
        int            gaps [2];
        fr[0] = f0; fr[1] = f1; fr[2] = f2;
        gaps[0] = gap0; gaps[1] = gap1;
        for (int i = 0; i < 3; i++) begin
            q_data  = fr[i];
            q_valid = 1'b1;
            tests_run++;
            if (q_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL q_ready_load beat %0d: got %b expected 1", i, q_ready);
            end
            @(posedge clk); #1;
            q_valid = 1'b0;
            q_data  = '0;
            if (i < 2) begin
                repeat (gaps[i]) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Called #1 after the final query-beat edge; checks latency and result fields.
    task automatic wait_result(input string name, input logic [2:0] exp_cls, input logic [7:0] exp_dist);
        int n;
        n = 0;
        tests_run++;
        if (busy !== 1'b1 || q_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s search_start: got busy=%b q_ready=%b expected busy=1 q_ready=0", name, busy, q_ready);
        end
        while (result_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n != 25) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges expected 25", name, n);
        end
        tests_run++;
        if (result_class !== exp_cls) begin
            tests_failed++;
            $display("FAIL %s result_class: got %0d expected %0d", name, result_class, exp_cls);
        end
        tests_run++;
        if (result_dist !== exp_dist) begin
            tests_failed++;
            $display("FAIL %s result_dist: got %0d expected %0d", name, result_dist, exp_dist);
        end
    endtask

    task automatic consume_result(input string name);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        tests_run++;
        if (result_valid !== 1'b0 || q_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s consume: got result_valid=%b q_ready=%b expected 0 and 1", name, result_valid, q_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run++;
        if (q_ready !== 1'b1 || frame_id !== 3'd0 || frame_index !== 2'd0 || result_valid !== 1'b0 ||
            result_class !== 3'd0 || result_dist !== 8'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got q_ready=%b id=%0d idx=%0d rv=%b cls=%0d dist=%0d busy=%b expected 1,0,0,0,0,0,0",
                     name, q_ready, frame_id, frame_index, result_valid, result_class, result_dist, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q_valid = 1'b0;
        q_data = '0;
        result_ready = 1'b0;
        set_default_rom();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_exact_match();
        load_frames(BASE, BASE, BASE, 0, 0);
        wait_result("exact_class4", 3'd4, 8'd0);
        consume_result("exact_class4");
    endtask

    task automatic test_single_bit();
        load_frames(BASE, BASE, BASE ^ 64'h1, 0, 0);
        wait_result("one_bit_flip", 3'd4, 8'd1);
        consume_result("one_bit_flip");
    endtask

    // Classes 2 and 5 both match exactly; all others differ in 1 bit per frame.
    task automatic test_tie();
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 3; f++)
                rom[c][f] = (c == 2 || c == 5) ? TIEQ : (TIEQ ^ 64'h1);
        load_frames(TIEQ, TIEQ, TIEQ, 0, 0);
        wait_result("tie_2_5", 3'd2, 8'd0);
        consume_result("tie_2_5");
    endtask

    // Every class is all-ones, query all-zero: every distance is 192, class 0 must win.
    task automatic test_max_distance();
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 3; f++)
                rom[c][f] = '1;
        load_frames('0, '0, '0, 0, 0);
        wait_result("max_dist", 3'd0, 8'd192);
        consume_result("max_dist");
    endtask

    // Idle cycles carry junk-free zeros on q_data; storing any of them would break the exact match.
    task automatic test_q_valid_gaps();
        set_default_rom();
        load_frames(BASE, BASE, BASE, 3, 2);
        wait_result("gapped_query", 3'd4, 8'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (result_valid !== 1'b1 || result_class !== 3'd4 || result_dist !== 8'd0 ||
                q_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: got rv=%b cls=%0d dist=%0d q_ready=%b expected 1,4,0,0",
                         i, result_valid, result_class, result_dist, q_ready);
            end
        end
        consume_result("gapped_query");
    endtask

    task automatic test_reset_mid_search();
        logic [FW-1:0] c7;
        set_default_rom();
        load_frames(BASE, BASE, BASE, 0, 0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_mid_search: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_outputs("reset_mid_search");
        c7 = rom[7][0];
        load_frames(c7, c7, c7, 0, 0);
        wait_result("class7_after_reset", 3'd7, 8'd0);
        consume_result("class7_after_reset");
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_single_bit();
        test_tie();
        test_max_distance();
        test_q_valid_gaps();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hamming_class_search.md
Name: hamming_class_search

Overview:
- Associative-search stage directly downstream of class_vec_gen.
- Accepts a query hypervector as NUM_FRAMES frames of FRAME_WIDTH bits, then walks every (class, frame) address of class_vec_gen.
- Accumulates the per-class Hamming distance to the query and returns the class with the minimum distance and that distance.
- Sits between the encoder output (query stream) and the classification result consumer.

Parameters:
- FRAME_WIDTH, 64, bits per frame.
- NUM_FRAMES, 3, frames per hypervector.
- NUM_CLASSES, 8, number of stored classes.
- CLASS_ID_WIDTH, 3, width of frame_id / result_class.
- FRAME_IDX_WIDTH, 2, width of frame_index.
- DIST_WIDTH, 8, distance width; must satisfy 2^DIST_WIDTH > FRAME_WIDTH*NUM_FRAMES.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- q_data  in  FRAME_WIDTH  query frame; frame 0 first.
- q_valid  in  1  query frame valid.
- q_ready  out  1  block accepts a query frame.
- frame_id  out  CLASS_ID_WIDTH  class address to class_vec_gen.
- frame_index  out  FRAME_IDX_WIDTH  frame address to class_vec_gen.
- class_vec_in  in  FRAME_WIDTH  class_vec_out from class_vec_gen; combinational, valid in the same cycle as the address.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_class  out  CLASS_ID_WIDTH  argmin class.
- result_dist  out  DIST_WIDTH  minimum Hamming distance.
- busy  out  1  high in SEARCH or DRAIN.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State returns to LOAD.
  - q_ready=1 from the next cycle.
  - frame_id, frame_index, result_valid, result_class, result_dist, busy all 0.
  - Query buffer, accumulator and best registers cleared.
  - Applies in any state; a partial query or search is discarded.
- States: LOAD, SEARCH, DRAIN, DONE.
- LOAD:
  - q_ready=1.
  - Each q_valid&q_ready edge stores q_data into buffer[ld_cnt] and increments ld_cnt.
  - Idle cycles (q_valid=0) do not advance ld_cnt.
  - On the beat with ld_cnt==NUM_FRAMES-1, go to SEARCH; cls_cnt=0 and frm_cnt=0.
- SEARCH:
  - Lasts exactly NUM_CLASSES*NUM_FRAMES cycles (24 at defaults); q_ready=0, busy=1.
  - frame_id=cls_cnt, frame_index=frm_cnt, both driven from registers.
  - Counters are nested: frm_cnt increments each cycle and wraps at NUM_FRAMES-1, at which point cls_cnt increments.
  - Pipeline stage 1 registers pc_q=popcount(class_vec_in ^ buffer[frm_cnt]) together with tags first_frame, last_frame and cls.
  - After the last address (cls=NUM_CLASSES-1, frm=NUM_FRAMES-1), go to DRAIN.
- Stage 2, active whenever pc_q is valid:
  - acc <= first_frame ? pc_q : acc+pc_q.
  - When last_frame: cand = (first_frame ? 0 : acc) + pc_q.
  - If cls==0 or cand < best_dist, then best_dist<=cand and best_cls<=cls.
  - Strict less-than, so ties keep the lower class index.
  - Arithmetic is unsigned DIST_WIDTH; no overflow by the parameter constraint.
- DRAIN:
  - One cycle; processes the final pc_q.
  - frame_id and frame_index hold their last values.
  - Next state is DONE.
- DONE:
  - result_valid=1; result_class=best_cls, result_dist=best_dist, both stable while result_valid=1.
  - q_ready=0.
  - On the result_valid&result_ready edge go to LOAD; result_valid=0 next cycle.
- Latency: result_valid rises in the 26th cycle after the final query-beat handshake edge at defaults (1+24+1).
- No new query is accepted until the result is consumed; there is no overlap between queries.

Test Plan:
- Query = class 4 vector (all three frames = 64'hD59... class-4 value from class_vec_gen), q_valid continuous -> result_class=4, result_dist=0, result_valid 26 cycles after the 3rd beat.
- Same query with bit 0 of frame 2 flipped -> result_class=4, result_dist=1.
- Stub ROM: classes 2 and 5 identical, query equal to them, all others differ -> result_class=2, result_dist=0 (tie rule).
- Stub ROM: class 0 all-ones, others all-ones too, query all-zero -> result_dist=192, result_class=0.
- q_valid gaps (1 beat, 3 idle, 1 beat, 2 idle, 1 beat) -> exactly 3 frames stored; result identical to the continuous case. Then hold result_ready=0 for 10 cycles -> result_valid and result fields stable, q_ready=0.
- rst_n=0 for one edge at SEARCH cycle 10 -> all outputs 0 and q_ready=1 next cycle. A fresh class-7 query then gives result_class=7, result_dist=0.
